// File: rtl/freq_meter_eq_ctrl.sv
// Equal-precision frequency meter: the gate opens and closes on clk_test edges and counts both clocks.
// A multi-cycle restoring divider then computes SYS_FREQ * cnt_test / cnt_ref.
module freq_meter_eq_ctrl #(
  parameter int unsigned SYS_FREQ     = 50_000_000,
  parameter int unsigned GATE_CYCLES  = 50_000_000,
  parameter int unsigned GUARD_CYCLES = 12_500_000,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned FREQ_W       = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              clk_test,
  input  logic              start,
  input  logic              cont_mode,
  output logic              busy,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_valid,
  output logic              no_signal,
  output logic              overflow
);

  // Numerator is widened beyond 2*CNT_W when SYS_FREQ alone needs more than CNT_W bits.
  localparam int unsigned SF_W    = $clog2(SYS_FREQ + 1);
  localparam int unsigned NUM_W   = (2 * CNT_W > CNT_W + SF_W) ? 2 * CNT_W : CNT_W + SF_W;
  localparam int unsigned TMR_GG  = (GATE_CYCLES > GUARD_CYCLES) ? GATE_CYCLES : GUARD_CYCLES;
  localparam int unsigned TMR_MAX = (TMR_GG > NUM_W + 1) ? TMR_GG : NUM_W + 1;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] T_GUARD = TMR_W'(GUARD_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_GATE  = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_DIV   = TMR_W'(NUM_W + 1);

  // state | meaning
  // IDLE  | waiting for start
  // PRE   | guard time, gate_s low
  // GATE  | gate_s high for GATE_CYCLES
  // CLOSE | waiting for the test-domain result toggle, or timeout
  // DIV   | load numerator, then one quotient bit per cycle
  // DONE  | one-cycle result publish
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_GATE, S_CLOSE, S_DIV, S_DONE} state_t;

  logic [1:0] rst_s_q, rst_t_q;
  logic       rst_s_n, rst_t_n;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) rst_s_q <= 2'b00;
    else            rst_s_q <= {rst_s_q[0], 1'b1};

  always_ff @(posedge clk_test or negedge sys_rst_n)
    if (!sys_rst_n) rst_t_q <= 2'b00;
    else            rst_t_q <= {rst_t_q[0], 1'b1};

  assign rst_s_n = rst_s_q[1];
  assign rst_t_n = rst_t_q[1];

  logic             gate_s_q;
  logic             gate_m_q, gate_a_q, gate_a_d1_q;
  logic [CNT_W-1:0] cnt_test_q, hold_t_q;
  logic             tgl_t_q;

  always_ff @(posedge clk_test or negedge rst_t_n)
    if (!rst_t_n) begin
      gate_m_q    <= 1'b0;
      gate_a_q    <= 1'b0;
      gate_a_d1_q <= 1'b0;
      cnt_test_q  <= '0;
      hold_t_q    <= '0;
      tgl_t_q     <= 1'b0;
    end else begin
      gate_m_q    <= gate_s_q;
      gate_a_q    <= gate_m_q;
      gate_a_d1_q <= gate_a_q;
      if (gate_a_q) begin
        if (!gate_a_d1_q)           cnt_test_q <= CNT_W'(1);
        else if (cnt_test_q != '1)  cnt_test_q <= cnt_test_q + CNT_W'(1);
      end
      if (!gate_a_q && gate_a_d1_q) begin
        hold_t_q <= cnt_test_q;
        tgl_t_q  <= ~tgl_t_q;
      end
    end

  logic             gate_rm_q, gate_r_q, gate_r_d1_q;
  logic [CNT_W-1:0] cnt_ref_q, cnt_test_s_q;
  logic             tgl_m_q, tgl_s_q, tgl_s_d1_q;
  logic             tgl_edge;

  assign tgl_edge = tgl_s_q ^ tgl_s_d1_q;

  always_ff @(posedge sys_clk or negedge rst_s_n)
    if (!rst_s_n) begin
      gate_rm_q    <= 1'b0;
      gate_r_q     <= 1'b0;
      gate_r_d1_q  <= 1'b0;
      cnt_ref_q    <= '0;
      tgl_m_q      <= 1'b0;
      tgl_s_q      <= 1'b0;
      tgl_s_d1_q   <= 1'b0;
      cnt_test_s_q <= '0;
    end else begin
      gate_rm_q   <= gate_a_q;
      gate_r_q    <= gate_rm_q;
      gate_r_d1_q <= gate_r_q;
      if (gate_r_q) begin
        if (!gate_r_d1_q)         cnt_ref_q <= CNT_W'(1);
        else if (cnt_ref_q != '1) cnt_ref_q <= cnt_ref_q + CNT_W'(1);
      end
      tgl_m_q    <= tgl_t_q;
      tgl_s_q    <= tgl_m_q;
      tgl_s_d1_q <= tgl_s_q;
      // hold_t has been static for several test cycles when the toggle edge shows up here
      if (tgl_edge) cnt_test_s_q <= hold_t_q;
    end

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              seen_q, seen_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [NUM_W-1:0]  quo_q, quo_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              no_sig_q, no_sig_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, valid_q;
  logic              tc;
  logic [NUM_W-1:0]  num;
  logic [CNT_W:0]    trial, diff;

  assign tc    = (timer_q == '0);
  assign num   = NUM_W'(SYS_FREQ) * NUM_W'(cnt_test_s_q);
  assign trial = {rem_q, quo_q[NUM_W-1]};
  assign diff  = trial - {1'b0, cnt_ref_q};

  always_comb begin
    state_d  = state_q;
    timer_d  = tc ? timer_q : timer_q - TMR_W'(1);
    seen_d   = seen_q | tgl_edge;
    rem_d    = rem_q;
    quo_d    = quo_q;
    freq_d   = freq_q;
    no_sig_d = no_sig_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE:
        if (start) begin
          state_d = S_PRE;
          timer_d = T_GUARD;
        end
      S_PRE:
        if (tc) begin
          state_d = S_GATE;
          timer_d = T_GATE;
          seen_d  = 1'b0;
        end
      S_GATE:
        if (tc) begin
          state_d = S_CLOSE;
          timer_d = T_GUARD;
        end
      S_CLOSE:
        if (seen_q && !gate_r_q) begin
          state_d = S_DIV;
          timer_d = T_DIV;
        end else if (tc) begin
          state_d  = S_DONE;
          freq_d   = '0;
          no_sig_d = 1'b1;
          ovf_d    = 1'b0;
        end
      S_DIV:
        if (timer_q == T_DIV) begin
          if (cnt_test_s_q == '0 || cnt_ref_q == '0) begin
            state_d  = S_DONE;
            freq_d   = '0;
            no_sig_d = 1'b1;
            ovf_d    = 1'b0;
          end else if (cnt_test_s_q == '1 || cnt_ref_q == '1) begin
            state_d  = S_DONE;
            freq_d   = '1;
            no_sig_d = 1'b0;
            ovf_d    = 1'b1;
          end else begin
            rem_d = '0;
            quo_d = num;
          end
        end else if (!tc) begin
          if (!diff[CNT_W]) begin
            rem_d = diff[CNT_W-1:0];
            quo_d = {quo_q[NUM_W-2:0], 1'b1};
          end else begin
            rem_d = trial[CNT_W-1:0];
            quo_d = {quo_q[NUM_W-2:0], 1'b0};
          end
        end else begin
          state_d  = S_DONE;
          no_sig_d = 1'b0;
          if ((quo_q >> FREQ_W) != '0) begin
            freq_d = '1;
            ovf_d  = 1'b1;
          end else begin
            freq_d = FREQ_W'(quo_q);
            ovf_d  = 1'b0;
          end
        end
      S_DONE:
        if (cont_mode) begin
          state_d = S_PRE;
          timer_d = T_GUARD;
        end else begin
          state_d = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_s_n)
    if (!rst_s_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      seen_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      freq_q   <= '0;
      no_sig_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      gate_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      seen_q   <= seen_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      freq_q   <= freq_d;
      no_sig_q <= no_sig_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d != S_IDLE);
      valid_q  <= (state_d == S_DONE);
      gate_s_q <= (state_d == S_GATE);
    end

  assign busy       = busy_q;
  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign no_signal  = no_sig_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_freq_meter_eq_ctrl.sv
// Directed and randomized bench for freq_meter_eq_ctrl; expected frequencies come from the
// stimulus clock period, with a tolerance for the one-reference-cycle gate uncertainty.
`timescale 1ns/1ps
module tb_freq_meter_eq_ctrl;

  localparam int unsigned SF    = 50_000_000;
  localparam int unsigned GATE  = 1000;
  localparam int unsigned GUARD = 250;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        clk_test = 1'b0;
  logic        clk_fast = 1'b0;
  logic        start = 1'b0, cont_mode = 1'b0;
  logic        start_b = 1'b0, cont_mode_b = 1'b0;
  logic        busy, freq_valid, no_signal, overflow;
  logic [31:0] freq;
  logic        busy8, valid8, nosig8, ovf8;
  logic [31:0] freq8;
  logic        busyq, validq, nosigq, ovfq;
  logic [19:0] freqq;

  freq_meter_eq_ctrl #(.SYS_FREQ(SF), .GATE_CYCLES(GATE), .GUARD_CYCLES(GUARD),
                       .CNT_W(24), .FREQ_W(32)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_test(clk_test), .start(start),
    .cont_mode(cont_mode), .busy(busy), .freq(freq), .freq_valid(freq_valid),
    .no_signal(no_signal), .overflow(overflow));

  freq_meter_eq_ctrl #(.SYS_FREQ(SF), .GATE_CYCLES(GATE), .GUARD_CYCLES(GUARD),
                       .CNT_W(8), .FREQ_W(32)) dut8 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_test(clk_fast), .start(start_b),
    .cont_mode(cont_mode_b), .busy(busy8), .freq(freq8), .freq_valid(valid8),
    .no_signal(nosig8), .overflow(ovf8));

  freq_meter_eq_ctrl #(.SYS_FREQ(SF), .GATE_CYCLES(GATE), .GUARD_CYCLES(GUARD),
                       .CNT_W(24), .FREQ_W(20)) dutq (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_test(clk_fast), .start(start_b),
    .cont_mode(cont_mode_b), .busy(busyq), .freq(freqq), .freq_valid(validq),
    .no_signal(nosigq), .overflow(ovfq));

  always #10 sys_clk = ~sys_clk;

  initial begin
    #1;
    forever #5 clk_fast = ~clk_fast;
  end

  // Test clock restarts a fixed 3.1 ns after a sys_clk edge so its edges never coincide with sys_clk.
  realtime half_ns = 50.0;
  bit      tst_run = 1'b0;
  always begin
    if (!tst_run) begin
      clk_test = 1'b0;
      @(posedge sys_clk);
      #3.1;
    end else begin
      clk_test = 1'b1;
      #(half_ns);
      clk_test = 1'b0;
      #(half_ns);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int nvalid   = 0;

  always @(posedge sys_clk) if (freq_valid === 1'b1) nvalid++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    n_assert++;
    assert (obs >= lo && obs <= hi)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_start();
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int waited);
    bit got = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      waited++;
      if (freq_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_valid_seen"}, 64'(got), 64'd1);
  endtask

  task automatic set_clk(input realtime half);
    tst_run = 1'b0;
    cycles(30);
    half_ns = half;
    tst_run = 1'b1;
    cycles(10);
  endtask

  // Reference: true frequency from the stimulus period; the gate can be short by one reference cycle.
  task automatic chk_freq(input string tag, input realtime period_ns);
    real f, tol;
    f   = 1.0e9 / period_ns;
    tol = f / 800.0 + 2.0;
    chk_rng(tag, longint'(freq), longint'(f - tol), longint'(f + tol));
  endtask

  initial begin
    int w, base, per_ps;
    bit g8, gq;
    logic [31:0] f8;
    logic [19:0] fq;
    logic o8, oq, ns8;

    #2 sys_rst_n = 1'b0;
    cycles(5);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_freq", 64'(freq), 64'd0);
    chk("rst_valid", 64'(freq_valid), 64'd0);
    chk("rst_nosig", 64'(no_signal), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    sys_rst_n = 1'b1;
    cycles(5);

    // 10 MHz single shot
    set_clk(50.0);
    base = nvalid;
    pulse_start();
    chk("s10_busy_up", 64'(busy), 64'd1);
    wait_valid("s10", 3000, w);
    chk_rng("s10_freq", longint'(freq), 9_990_000, 10_010_000);
    chk("s10_nosig", 64'(no_signal), 64'd0);
    chk("s10_ovf", 64'(overflow), 64'd0);
    chk("s10_busy_done", 64'(busy), 64'd1);
    @(negedge sys_clk);
    chk("s10_busy_fall", 64'(busy), 64'd0);
    cycles(50);
    chk("s10_one_valid", 64'(nvalid - base), 64'd1);

    // 33.333 MHz continuous
    set_clk(15.0);
    cont_mode = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_valid("cont", 3000, w);
      chk_rng("cont_freq", longint'(freq), 33_333_333 - 33_333, 33_333_333 + 33_333);
      if (k > 0) chk_rng("cont_interval", longint'(w), 1250, 1450);
      if (k == 2) cont_mode = 1'b0;
    end
    cycles(2);
    chk("cont_idle", 64'(busy), 64'd0);

    // Random test-clock frequencies
    for (int r = 0; r < 4; r++) begin
      per_ps = 2 * $urandom_range(7500, 200000);
      set_clk(realtime'(per_ps) / 2000.0);
      pulse_start();
      wait_valid("rnd", 3000, w);
      chk_freq("rnd_freq", realtime'(per_ps) / 1000.0);
      chk("rnd_nosig", 64'(no_signal), 64'd0);
    end

    // No signal, then recovery at 1 MHz
    tst_run = 1'b0;
    cycles(30);
    base = nvalid;
    pulse_start();
    wait_valid("nosig", 3000, w);
    chk("nosig_freq", 64'(freq), 64'd0);
    chk("nosig_flag", 64'(no_signal), 64'd1);
    chk("nosig_ovf", 64'(overflow), 64'd0);
    cycles(50);
    chk("nosig_one_valid", 64'(nvalid - base), 64'd1);
    set_clk(500.0);
    pulse_start();
    wait_valid("rec1m", 3000, w);
    chk("rec1m_nosig", 64'(no_signal), 64'd0);
    chk_freq("rec1m_freq", 1000.0);

    // Start hammered while busy
    set_clk(50.0);
    base = nvalid;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (freq_valid === 1'b1) begin
        start = 1'b0;
        break;
      end
      start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    cycles(100);
    chk("ham_one_meas", 64'(nvalid - base), 64'd1);
    chk("ham_busy", 64'(busy), 64'd0);

    // Overflow: counter saturation (CNT_W=8) and quotient above FREQ_W (FREQ_W=20), 100 MHz
    g8 = 1'b0; gq = 1'b0;
    f8 = '0; fq = '0; o8 = 1'b0; oq = 1'b0; ns8 = 1'b1;
    @(negedge sys_clk) start_b = 1'b1;
    @(negedge sys_clk) start_b = 1'b0;
    for (int i = 0; i < 3000 && !(g8 && gq); i++) begin
      @(negedge sys_clk);
      if (valid8 === 1'b1) begin g8 = 1'b1; f8 = freq8; o8 = ovf8; ns8 = nosig8; end
      if (validq === 1'b1) begin gq = 1'b1; fq = freqq; oq = ovfq; end
    end
    chk("sat_valid_seen", 64'(g8), 64'd1);
    chk("sat_ovf", 64'(o8), 64'd1);
    chk("sat_freq", 64'(f8), 64'hFFFF_FFFF);
    chk("sat_nosig", 64'(ns8), 64'd0);
    chk("quo_valid_seen", 64'(gq), 64'd1);
    chk("quo_ovf", 64'(oq), 64'd1);
    chk("quo_freq", 64'(fq), 64'hF_FFFF);

    // Reset during GATE
    base = nvalid;
    pulse_start();
    cycles(GUARD + 300);
    chk("mid_busy_pre", 64'(busy), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_freq", 64'(freq), 64'd0);
    cycles(3);
    sys_rst_n = 1'b1;
    cycles(2000);
    chk("mid_rst_no_valid", 64'(nvalid - base), 64'd0);
    chk("mid_rst_idle", 64'(busy), 64'd0);

    // Normal measurement after reset
    pulse_start();
    wait_valid("post", 3000, w);
    chk_rng("post_freq", longint'(freq), 9_990_000, 10_010_000);
    chk("post_nosig", 64'(no_signal), 64'd0);

    // Test clock stops mid-gate
    pulse_start();
    cycles(GUARD + 500);
    tst_run = 1'b0;
    wait_valid("stop", 3000, w);
    chk("stop_nosig", 64'(no_signal), 64'd1);
    chk("stop_freq", 64'(freq), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
